// File: rtl/stack_pkg.sv
// Shared defaults and size helpers for the data and return stacks.
package stack_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_DEPTH = 16;

    // TOS and NEXT live in registers, so the RAM holds the rest.
    function automatic int unsigned spill_size(input int unsigned depth);
        return depth - 2;
    endfunction

    // Pointer width needed to address n spill words (at least 1 bit).
    function automatic int unsigned ptr_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    localparam int unsigned DEF_SPILL = spill_size(DEF_DEPTH);
    localparam int unsigned DEF_PTR_W = ptr_width(DEF_SPILL);

endpackage

// File: rtl/stack_ram.sv
// Spill RAM: synchronous write, asynchronous read. Shared with the return stack.
module stack_ram #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned WORDS = 14,
    parameter int unsigned PTR_W = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [WORDS];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_stack.sv
// Data stack: TOS/NEXT registers plus a spill RAM addressed by a wrapping pointer.
// Optional macro DSTACK_GUARD_EN: suppresses push-on-full / pop-on-empty and
// raises sticky ovf/unf flags. Without it those operations proceed and flags stay 0.
module data_stack
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned PTR_W = DEF_PTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_push,
    input  logic             data_pop,
    input  logic             dw_tos,
    input  logic             dw_next,
    input  logic [WIDTH-1:0] tos_in,
    input  logic [WIDTH-1:0] next_in,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] next,
    output logic             tos_or,
    output logic [PTR_W+1:0] depth,
    output logic             empty,
    output logic             full,
    input  logic             err_clr,
    output logic             ovf,
    output logic             unf
);

    localparam int unsigned SPILL = spill_size(DEPTH);
    localparam int unsigned DW    = PTR_W + 2;

    localparam logic [PTR_W-1:0] SP_MAX    = PTR_W'(SPILL - 1);
    localparam logic [PTR_W-1:0] SP_ONE    = PTR_W'(1);
    localparam logic [DW-1:0]    DEPTH_MAX = DW'(DEPTH);
    localparam logic [DW-1:0]    D_ONE     = DW'(1);
    localparam logic [DW-1:0]    D_TWO     = DW'(2);

    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] next_q, next_d;
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             push_op, pop_op;
    logic             ovf_evt, unf_evt;
    logic             is_empty, is_full;
    logic [PTR_W-1:0] sp_inc, sp_dec;
    logic             ram_we;
    logic [WIDTH-1:0] ram_rdata;

    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == DEPTH_MAX);

    // Push and pop together is illegal and degrades to a plain register write.
    assign push_op = data_push & ~data_pop;
    assign pop_op  = data_pop & ~data_push;

`ifdef DSTACK_GUARD_EN
    assign ovf_evt = push_op & is_full;
    assign unf_evt = pop_op & is_empty;
`else
    assign ovf_evt = 1'b0;
    assign unf_evt = 1'b0;
`endif

    // Pointer arithmetic modulo the spill size, which need not be a power of two.
    assign sp_inc = (sp_q == SP_MAX) ? '0 : sp_q + SP_ONE;
    assign sp_dec = (sp_q == '0) ? SP_MAX : sp_q - SP_ONE;

    stack_ram #(
        .WIDTH (WIDTH),
        .WORDS (SPILL),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (sp_q),
        .wdata (next_q),
        .raddr (sp_dec),
        .rdata (ram_rdata)
    );

    // Next-state for the stack registers, pointer, depth and sticky flags.
    always_comb begin
        tos_d   = tos_q;
        next_d  = next_q;
        sp_d    = sp_q;
        depth_d = depth_q;
        ram_we  = 1'b0;

        if (ovf_evt || unf_evt) begin
            // Guarded error: the whole operation is dropped, strobes included.
        end else if (push_op) begin
            if (depth_q >= D_TWO) begin
                ram_we = 1'b1;
                sp_d   = sp_inc;
            end
            next_d  = dw_next ? next_in : tos_q;
            tos_d   = dw_tos ? tos_in : tos_q;
            depth_d = is_full ? depth_q : depth_q + D_ONE;
        end else if (pop_op) begin
            if (depth_q > D_TWO) begin
                sp_d = sp_dec;
            end
            next_d  = dw_next ? next_in : ram_rdata;
            tos_d   = dw_tos ? tos_in : next_q;
            depth_d = is_empty ? depth_q : depth_q - D_ONE;
        end else begin
            if (dw_tos) begin
                tos_d = tos_in;
            end
            if (dw_next) begin
                next_d = next_in;
            end
        end

        // A new error in the same cycle as err_clr wins.
        ovf_d = (ovf_q & ~err_clr) | ovf_evt;
        unf_d = (unf_q & ~err_clr) | unf_evt;
    end

    // State registers with synchronous reset; RAM contents are left alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            tos_q   <= '0;
            next_q  <= '0;
            sp_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            tos_q   <= tos_d;
            next_q  <= next_d;
            sp_q    <= sp_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign tos    = tos_q;
    assign next   = next_q;
    assign tos_or = |tos_q;
    assign depth  = depth_q;
    assign empty  = is_empty;
    assign full   = is_full;
    assign ovf    = ovf_q;
    assign unf    = unf_q;

endmodule

// File: tb/tb_data_stack.sv
// Scoreboard bench for data_stack (DEPTH=4 so overflow and pointer wrap are reachable).
module tb_data_stack;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;

    localparam logic [3:0] M_T = 4'b0001;
    localparam logic [3:0] M_N = 4'b0010;
    localparam logic [3:0] M_D = 4'b0100;
    localparam logic [3:0] M_F = 4'b1000;
    localparam logic [3:0] M_ALL = 4'b1111;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             data_push = 1'b0;
    logic             data_pop = 1'b0;
    logic             dw_tos = 1'b0;
    logic             dw_next = 1'b0;
    logic [WIDTH-1:0] tos_in = '0;
    logic [WIDTH-1:0] next_in = '0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] next;
    logic             tos_or;
    logic [PTR_W+1:0] depth;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    data_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_push (data_push),
        .data_pop  (data_pop),
        .dw_tos    (dw_tos),
        .dw_next   (dw_next),
        .tos_in    (tos_in),
        .next_in   (next_in),
        .tos       (tos),
        .next      (next),
        .tos_or    (tos_or),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .err_clr   (err_clr),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        int         tgt;
        logic [3:0] m;
        logic [15:0] t;
        logic [15:0] n;
        logic [3:0] d;
        logic       o;
        logic       u;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   next_id = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s (vector %0d): got %0h, expected %0h", nm, id, act, req);
        end
    endtask

    // Drive one cycle of strobes starting at a falling edge.
    task automatic step(input logic r, input logic ps, input logic pp, input logic dt,
                        input logic dn, input logic cl, input logic [15:0] ti,
                        input logic [15:0] ni);
        @(negedge clk);
        rst       = r;
        data_push = ps;
        data_pop  = pp;
        dw_tos    = dt;
        dw_next   = dn;
        err_clr   = cl;
        tos_in    = ti;
        next_in   = ni;
    endtask

    // Expected state visible one edge after the strobes just driven.
    task automatic exp_st(input logic [3:0] m, input logic [15:0] t, input logic [15:0] n,
                          input logic [3:0] d, input logic o, input logic u);
        exp_t e;
        e.id  = next_id;
        e.tgt = cyc + 1;
        e.m   = m;
        e.t   = t;
        e.n   = n;
        e.d   = d;
        e.o   = o;
        e.u   = u;
        sb.push_back(e);
        next_id++;
    endtask

    task automatic push_v(input logic [15:0] v);
        step(0, 1, 0, 1, 0, 0, v, 16'h0);
    endtask

    task automatic pop_v();
        step(0, 0, 1, 0, 0, 0, 16'h0, 16'h0);
    endtask

    task automatic do_rst();
        step(1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        exp_st(M_ALL, 16'h0, 16'h0, 4'd0, 0, 0);
    endtask

    // Monitor: compare every expectation that has come due.
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].tgt <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.m[0]) begin
                chk("tos", mon_e.id, 32'(tos), 32'(mon_e.t));
                chk("tos_or", mon_e.id, 32'(tos_or), 32'(|mon_e.t));
            end
            if (mon_e.m[1]) chk("next", mon_e.id, 32'(next), 32'(mon_e.n));
            if (mon_e.m[2]) begin
                chk("depth", mon_e.id, 32'(depth), 32'(mon_e.d));
                chk("empty", mon_e.id, 32'(empty), 32'(mon_e.d == 4'd0));
                chk("full", mon_e.id, 32'(full), 32'(mon_e.d == 4'(DEPTH)));
            end
            if (mon_e.m[3]) begin
                chk("ovf", mon_e.id, 32'(ovf), 32'(mon_e.o));
                chk("unf", mon_e.id, 32'(unf), 32'(mon_e.u));
            end
        end
    end

    initial begin
        // Reset and basic pushes.
        do_rst();
        push_v(16'h0001); exp_st(M_ALL, 16'h0001, 16'h0000, 4'd1, 0, 0);
        push_v(16'h0002); exp_st(M_ALL, 16'h0002, 16'h0001, 4'd2, 0, 0);
        push_v(16'h0003); exp_st(M_ALL, 16'h0003, 16'h0002, 4'd3, 0, 0);
        // add: NEXT refilled from spill RAM.
        step(0, 0, 1, 1, 0, 0, 16'h0005, 16'h0); exp_st(M_ALL, 16'h0005, 16'h0001, 4'd2, 0, 0);
        // swap.
        step(0, 0, 0, 1, 1, 0, 16'h0001, 16'h0005);
        exp_st(M_ALL, 16'h0001, 16'h0005, 4'd2, 0, 0);
        // Illegal push+pop behaves as a register write only.
        step(0, 1, 1, 1, 0, 0, 16'h00AA, 16'h0);
        exp_st(M_ALL, 16'h00AA, 16'h0005, 4'd2, 0, 0);

        // Overflow and pointer wrap.
        do_rst();
        push_v(16'h0010); exp_st(M_T | M_D, 16'h0010, 16'h0, 4'd1, 0, 0);
        push_v(16'h0011); exp_st(M_T | M_D, 16'h0011, 16'h0, 4'd2, 0, 0);
        push_v(16'h0012); exp_st(M_T | M_D, 16'h0012, 16'h0, 4'd3, 0, 0);
        push_v(16'h0013); exp_st(M_ALL, 16'h0013, 16'h0012, 4'd4, 0, 0);
`ifdef DSTACK_GUARD_EN
        push_v(16'h0014); exp_st(M_ALL, 16'h0013, 16'h0012, 4'd4, 1, 0);
        step(0, 1, 0, 1, 0, 1, 16'h0015, 16'h0); exp_st(M_ALL, 16'h0013, 16'h0012, 4'd4, 1, 0);
        step(0, 0, 0, 0, 0, 1, 16'h0, 16'h0); exp_st(M_F, 16'h0, 16'h0, 4'd0, 0, 0);
        pop_v(); exp_st(M_ALL, 16'h0012, 16'h0011, 4'd3, 0, 0);
        pop_v(); exp_st(M_ALL, 16'h0011, 16'h0010, 4'd2, 0, 0);
`else
        push_v(16'h0014); exp_st(M_ALL, 16'h0014, 16'h0013, 4'd4, 0, 0);
        step(0, 1, 0, 1, 0, 1, 16'h0015, 16'h0); exp_st(M_ALL, 16'h0015, 16'h0014, 4'd4, 0, 0);
        step(0, 0, 0, 0, 0, 1, 16'h0, 16'h0); exp_st(M_F, 16'h0, 16'h0, 4'd0, 0, 0);
        pop_v(); exp_st(M_ALL, 16'h0014, 16'h0013, 4'd3, 0, 0);
        pop_v(); exp_st(M_ALL, 16'h0013, 16'h0012, 4'd2, 0, 0);
`endif

        // Underflow on an empty stack with preloaded registers.
        do_rst();
        step(0, 0, 0, 1, 1, 0, 16'h0021, 16'h0022);
        exp_st(M_ALL, 16'h0021, 16'h0022, 4'd0, 0, 0);
`ifdef DSTACK_GUARD_EN
        pop_v(); exp_st(M_ALL, 16'h0021, 16'h0022, 4'd0, 0, 1);
        step(0, 0, 1, 0, 0, 1, 16'h0, 16'h0); exp_st(M_ALL, 16'h0021, 16'h0022, 4'd0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 16'h0, 16'h0); exp_st(M_D | M_F, 16'h0, 16'h0, 4'd0, 0, 0);
`else
        pop_v(); exp_st(M_T | M_D | M_F, 16'h0022, 16'h0, 4'd0, 0, 0);
        step(0, 0, 1, 0, 0, 1, 16'h0, 16'h0); exp_st(M_D | M_F, 16'h0, 16'h0, 4'd0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 16'h0, 16'h0); exp_st(M_D | M_F, 16'h0, 16'h0, 4'd0, 0, 0);
`endif

        // Reset mid-stream wins over a concurrent push.
        push_v(16'h0031);
        push_v(16'h0032);
        push_v(16'h0033); exp_st(M_T | M_D, 16'h0033, 16'h0, 4'd3, 0, 0);
        step(1, 1, 0, 1, 0, 0, 16'h0044, 16'h0); exp_st(M_ALL, 16'h0, 16'h0, 4'd0, 0, 0);
        push_v(16'h0007); exp_st(M_ALL, 16'h0007, 16'h0000, 4'd1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 16'h0, 16'h0);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
